// File: rtl/int_sequencer.sv
// int_sequencer: interrupt entry/return sequencer driving EPC, IE, in-service and PC redirect
module int_sequencer #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        int_req,
    input  logic [2:0]  ints,
    input  logic [31:0] pc_cur,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        epc_w_en,
    output logic [31:0] epc_w_data,
    output logic        ie_w_en,
    output logic        ie_w_data,
    output logic        irs_set_en,
    output logic        irs_clr_en,
    output logic [2:0]  irs_w_mask,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] pc_redirect_addr,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SAVE, JUMP, RET} state_t;
    state_t      state;
    logic [2:0]  lvl;
    logic [31:0] ret_pc;
    logic [2:0]  isv;
    logic [2:0]  set_mask;
    logic [2:0]  hi_mask;
    logic [31:0] vec_addr;
    logic        s, j, r;
    // one-hot of the entered level and of the most recently entered (highest) in-service level
    always_comb begin
        set_mask = 3'b001 << (lvl - 3'd1);
        hi_mask  = isv[2] ? 3'b100 : isv[1] ? 3'b010 : isv[0] ? 3'b001 : 3'b000;
        vec_addr = VEC_BASE + {29'd0, lvl - 3'd1} * VEC_STRIDE;
    end
    // sequencer state, latched level/return address and in-service shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lvl    <= '0;
            ret_pc <= '0;
            isv    <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (eret) begin
                        state <= RET;
                    end else if (int_req && ints != 3'd0) begin
                        state  <= SAVE;
                        lvl    <= ints;
                        ret_pc <= pc_cur;
                    end
                end
                SAVE: begin
                    isv   <= isv | set_mask;
                    state <= JUMP;
                end
                JUMP: state <= IDLE;
                RET: begin
                    isv   <= isv & ~hi_mask;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // outputs decoded from the registered state only; en gates every strobe
    always_comb begin
        s                = state == SAVE;
        j                = state == JUMP;
        r                = state == RET;
        busy             = state != IDLE;
        epc_w_en         = en & s;
        epc_w_data       = s ? ret_pc : 32'd0;
        ie_w_en          = en & (s | r);
        ie_w_data        = r;
        irs_set_en       = en & s;
        irs_clr_en       = en & r;
        irs_w_mask       = s ? set_mask : r ? ~hi_mask : 3'b000;
        flush            = en & (s | j | r);
        pc_redirect      = en & (j | r);
        pc_redirect_addr = j ? vec_addr : r ? epc : 32'd0;
    end
endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: directed table plus randomized run against a pending-operation queue model
module tb_int_sequencer;
    logic        clk = 1'b0;
    logic        rst, en, int_req, eret;
    logic [2:0]  ints;
    logic [31:0] pc_cur, epc;
    logic        epc_w_en, ie_w_en, ie_w_data, irs_set_en, irs_clr_en, flush, pc_redirect, busy;
    logic [31:0] epc_w_data, pc_redirect_addr;
    logic [2:0]  irs_w_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .int_req(int_req), .ints(ints), .pc_cur(pc_cur),
        .eret(eret), .epc(epc), .epc_w_en(epc_w_en), .epc_w_data(epc_w_data),
        .ie_w_en(ie_w_en), .ie_w_data(ie_w_data), .irs_set_en(irs_set_en),
        .irs_clr_en(irs_clr_en), .irs_w_mask(irs_w_mask), .flush(flush),
        .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr), .busy(busy)
    );

    // each accepted request becomes a list of one-cycle operations consumed on en=1 cycles
    typedef struct {
        logic        sv;
        logic        jp;
        logic        rt;
        logic [31:0] data;
        logic [2:0]  mask;
    } op_t;
    op_t        q[$];
    logic [2:0] isv_m;

    typedef struct {
        int unsigned rst, en, irq, ints, pc, eret, epc;
        int unsigned busy, fl, rd, addr, mask, set, clr, ew, ed, iw, id;
    } vec_t;
    vec_t tbl[31];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic model_check();
        op_t o;
        o = q.size() != 0 ? q[0] : '{sv: 1'b0, jp: 1'b0, rt: 1'b0, data: 32'd0, mask: 3'd0};
        chk("m_busy", 32'(busy), 32'(q.size() != 0));
        chk("m_epc_w_en", 32'(epc_w_en), 32'(en & o.sv));
        chk("m_epc_w_data", epc_w_data, o.sv ? o.data : 32'd0);
        chk("m_ie_w_en", 32'(ie_w_en), 32'(en & (o.sv | o.rt)));
        chk("m_ie_w_data", 32'(ie_w_data), 32'(o.rt));
        chk("m_irs_set_en", 32'(irs_set_en), 32'(en & o.sv));
        chk("m_irs_clr_en", 32'(irs_clr_en), 32'(en & o.rt));
        chk("m_irs_w_mask", 32'(irs_w_mask), 32'((o.sv | o.rt) ? o.mask : 3'd0));
        chk("m_flush", 32'(flush), 32'(en & (o.sv | o.jp | o.rt)));
        chk("m_pc_redirect", 32'(pc_redirect), 32'(en & (o.jp | o.rt)));
        chk("m_pc_redirect_addr", pc_redirect_addr, o.jp ? o.data : o.rt ? epc : 32'd0);
    endtask

    task automatic model_update();
        logic [2:0] h;
        int         l;
        if (rst) begin
            q.delete();
            isv_m = 3'd0;
        end else if (en) begin
            if (q.size() != 0) begin
                void'(q.pop_front());
            end else if (eret) begin
                h = 3'd0;
                for (int b = 0; b < 3; b++) if (isv_m[b]) h = 3'(1 << b);
                q.push_back('{sv: 1'b0, jp: 1'b0, rt: 1'b1, data: 32'd0, mask: ~h});
                isv_m = isv_m & ~h;
            end else if (int_req && ints != 3'd0) begin
                l = int'(ints) - 1;
                q.push_back('{sv: 1'b1, jp: 1'b0, rt: 1'b0, data: pc_cur, mask: 3'(1 << l)});
                q.push_back('{sv: 1'b0, jp: 1'b1, rt: 1'b0, data: 32'h1000 + 32'(l * 16), mask: 3'd0});
                isv_m = isv_m | 3'(1 << l);
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic i, input logic [2:0] s,
                         input logic [31:0] p, input logic er, input logic [31:0] ep);
        @(negedge clk);
        rst = r; en = e; int_req = i; ints = s; pc_cur = p; eret = er; epc = ep;
        #1;
        model_check();
    endtask

    task automatic table_check(input int k, input vec_t t);
        chk($sformatf("r%0d_busy", k), 32'(busy), t.busy);
        chk($sformatf("r%0d_flush", k), 32'(flush), t.fl);
        chk($sformatf("r%0d_pc_redirect", k), 32'(pc_redirect), t.rd);
        chk($sformatf("r%0d_pc_redirect_addr", k), pc_redirect_addr, t.addr);
        chk($sformatf("r%0d_irs_w_mask", k), 32'(irs_w_mask), t.mask);
        chk($sformatf("r%0d_irs_set_en", k), 32'(irs_set_en), t.set);
        chk($sformatf("r%0d_irs_clr_en", k), 32'(irs_clr_en), t.clr);
        chk($sformatf("r%0d_epc_w_en", k), 32'(epc_w_en), t.ew);
        chk($sformatf("r%0d_epc_w_data", k), epc_w_data, t.ed);
        chk($sformatf("r%0d_ie_w_en", k), 32'(ie_w_en), t.iw);
        chk($sformatf("r%0d_ie_w_data", k), 32'(ie_w_data), t.id);
    endtask

    initial begin
        tbl = '{
            //  rst en irq ints pc      eret epc       busy fl rd addr      mask set clr ew ed      iw id
            '{0, 1, 1, 2, 'h40,  0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 0,       1, 1, 0, 0,       2, 1, 0, 1, 'h40,  1, 0},
            '{0, 1, 0, 0, 0,     0, 0,       1, 1, 1, 'h1010,  0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     1, 'h40,    0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 'h40,    1, 1, 1, 'h40,    5, 0, 1, 0, 0,      1, 1},
            '{0, 1, 1, 1, 'h100, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 0,       1, 1, 0, 0,       1, 1, 0, 1, 'h100, 1, 0},
            '{0, 1, 0, 0, 0,     0, 0,       1, 1, 1, 'h1000,  0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 1, 3, 'h200, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 0,       1, 1, 0, 0,       4, 1, 0, 1, 'h200, 1, 0},
            '{0, 1, 0, 0, 0,     0, 0,       1, 1, 1, 'h1020,  0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     1, 'h200,   0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 'h200,   1, 1, 1, 'h200,   3, 0, 1, 0, 0,      1, 1},
            '{0, 1, 0, 0, 0,     1, 'h100,   0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 'h100,   1, 1, 1, 'h100,   6, 0, 1, 0, 0,      1, 1},
            '{0, 1, 1, 1, 'h300, 1, 'h500,   0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 1, 1, 'h300, 0, 'h500,   1, 1, 1, 'h500,   7, 0, 1, 0, 0,      1, 1},
            '{0, 1, 1, 1, 'h300, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 0,       1, 1, 0, 0,       1, 1, 0, 1, 'h300, 1, 0},
            '{0, 0, 0, 0, 0,     0, 0,       1, 0, 0, 'h1000,  0, 0, 0, 0, 0,      0, 0},
            '{0, 0, 1, 2, 0,     1, 0,       1, 0, 0, 'h1000,  0, 0, 0, 0, 0,      0, 0},
            '{0, 0, 0, 0, 0,     0, 0,       1, 0, 0, 'h1000,  0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 0,       1, 1, 1, 'h1000,  0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 1, 2, 'h80,  0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{1, 1, 0, 0, 0,     0, 0,       1, 1, 0, 0,       2, 1, 0, 1, 'h80,  1, 0},
            '{0, 1, 0, 0, 0,     1, 'h44,    0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 'h44,    1, 1, 1, 'h44,    7, 0, 1, 0, 0,      1, 1},
            '{0, 0, 1, 3, 'h9,   0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 1, 0, 'h9,   0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0},
            '{0, 1, 0, 0, 0,     0, 0,       0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0}
        };
        rst = 1'b1; en = 1'b0; int_req = 1'b0; ints = 3'd0; pc_cur = 32'd0; eret = 1'b0; epc = 32'd0;
        q.delete();
        isv_m = 3'd0;
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 3'd1, 32'h123, 1'b1, 32'h456);
        model_update();
        for (int k = 0; k < 31; k++) begin
            drive(1'(tbl[k].rst), 1'(tbl[k].en), 1'(tbl[k].irq), 3'(tbl[k].ints),
                  tbl[k].pc, 1'(tbl[k].eret), tbl[k].epc);
            table_check(k, tbl[k]);
            model_update();
        end
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom,
                  1'($urandom_range(0, 3) == 0), $urandom);
            chk("set_clr_exclusive", 32'(irs_set_en & irs_clr_en), 32'd0);
            model_update();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
